// File: rtl/spi_link_pkg.sv
// spi_link_pkg: shared constants and state type for the SPI pixel link receiver
package spi_link_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int LINES = 4;
  localparam int NIBBLES = DATA_WIDTH / LINES;
  localparam int H_PIXELS = 160;
  localparam int V_PIXELS = 90;
  typedef enum logic {IDLE, SHIFT} rx_state_t;
endpackage

// File: rtl/pin_synchronizer.sv
// pin_synchronizer: multi-stage flop chain bringing asynchronous pins into clk_in
module pin_synchronizer #(
  parameter int WIDTH = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);
  logic [WIDTH-1:0] ff_q [STAGES];
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < STAGES; i++) ff_q[i] <= '0;
    end else begin
      ff_q[0] <= d_in;
      for (int i = 1; i < STAGES; i++) ff_q[i] <= ff_q[i-1];
    end
  end
  assign q_out = ff_q[STAGES-1];
endmodule

// File: rtl/spi_receive_con.sv
// spi_receive_con: deserializes the 4-line SPI pixel link into pixels with coordinates
module spi_receive_con #(
  parameter int DATA_WIDTH = spi_link_pkg::DATA_WIDTH,
  parameter int LINES = spi_link_pkg::LINES,
  parameter int H_PIXELS = spi_link_pkg::H_PIXELS,
  parameter int V_PIXELS = spi_link_pkg::V_PIXELS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        chip_clk_in,
  input  logic                        chip_sel_in,
  input  logic [LINES-1:0]            chip_data_in,
  input  logic                        final_pixel_in,
  output logic                        pixel_valid_out,
  output logic [DATA_WIDTH-1:0]       pixel_data_out,
  output logic [$clog2(H_PIXELS)-1:0] hcount_out,
  output logic [$clog2(V_PIXELS)-1:0] vcount_out,
  output logic                        frame_done_out,
  output logic                        error_out
);
  import spi_link_pkg::*;
  localparam int NIB = DATA_WIDTH / LINES;
  localparam int CW = $clog2(NIB) + 1;
  localparam int HW = $clog2(H_PIXELS);
  localparam int VW = $clog2(V_PIXELS);
  localparam int SW = LINES + 3;
  logic [SW-1:0] s;
  logic clk_p_q, edge_q, cs_q, cs_p_q, last_q;
  logic [LINES-1:0] dat_q;
  rx_state_t state_q;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hc_q;
  logic [VW-1:0] vc_q;
  logic done, at_end, h_wrap;
  pin_synchronizer #(.WIDTH(SW), .STAGES(SYNC_STAGES)) u_sync (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .d_in({chip_clk_in, chip_sel_in, final_pixel_in, chip_data_in}),
    .q_out(s)
  );
  // cs_p_q resets low so a chip select held low across reset never looks like a falling edge
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clk_p_q <= 1'b0;
      edge_q <= 1'b0;
      cs_q <= 1'b0;
      cs_p_q <= 1'b0;
      last_q <= 1'b0;
      dat_q <= '0;
    end else begin
      clk_p_q <= s[SW-1];
      edge_q <= s[SW-1] & ~clk_p_q;
      cs_q <= s[SW-2];
      cs_p_q <= cs_q;
      last_q <= s[LINES];
      dat_q <= s[LINES-1:0];
    end
  end
  always_comb begin
    sr_d = DATA_WIDTH'({sr_q, dat_q});
    done = edge_q && cnt_q == CW'(NIB - 1);
    cnt_d = done ? '0 : edge_q ? cnt_q + CW'(1) : cnt_q;
    h_wrap = hc_q == HW'(H_PIXELS - 1);
    at_end = h_wrap && vc_q == VW'(V_PIXELS - 1);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      hc_q <= '0;
      vc_q <= '0;
      pixel_valid_out <= 1'b0;
      pixel_data_out <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
      frame_done_out <= 1'b0;
      error_out <= 1'b0;
    end else begin
      pixel_valid_out <= 1'b0;
      frame_done_out <= 1'b0;
      error_out <= 1'b0;
      if (state_q == IDLE) begin
        cnt_q <= '0;
        if (cs_p_q && !cs_q) state_q <= SHIFT;
      end else begin
        if (edge_q) sr_q <= sr_d;
        cnt_q <= cnt_d;
        if (done) begin
          pixel_valid_out <= 1'b1;
          pixel_data_out <= sr_d;
          hcount_out <= hc_q;
          vcount_out <= vc_q;
          if (last_q) begin
            frame_done_out <= 1'b1;
            error_out <= !at_end;
            hc_q <= '0;
            vc_q <= '0;
          end else begin
            error_out <= at_end;
            hc_q <= h_wrap ? '0 : hc_q + HW'(1);
            vc_q <= !h_wrap ? vc_q : vc_q == VW'(V_PIXELS - 1) ? '0 : vc_q + VW'(1);
          end
        end
        // an edge arriving with the cs rise is taken first; only a leftover partial pixel is an error
        if (cs_q) begin
          state_q <= IDLE;
          cnt_q <= '0;
        end
        if (cs_q && cnt_d != '0) error_out <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_receive_con.sv
// tb_spi_receive_con: randomized scoreboard bench for the SPI pixel link receiver
module tb_spi_receive_con;
  localparam int DW = 8;
  localparam int LN = 4;
  localparam int NIB = DW / LN;
  localparam int H = 16;
  localparam int V = 6;
  localparam int HV = H * V;
  logic clk_in = 0, rst_in = 1, chip_clk_in = 0, chip_sel_in = 1, final_pixel_in = 0;
  logic [LN-1:0] chip_data_in = '0;
  logic pixel_valid_out, frame_done_out, error_out;
  logic [DW-1:0] pixel_data_out;
  logic [$clog2(H)-1:0] hcount_out;
  logic [$clog2(V)-1:0] vcount_out;
  typedef struct {bit pix; int d; int h; int v; bit fr; bit er;} exp_t;
  exp_t q[$];
  int ncmp = 0, nfail = 0, p = 0;

  spi_receive_con #(.DATA_WIDTH(DW), .LINES(LN), .H_PIXELS(H), .V_PIXELS(V), .SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .chip_clk_in(chip_clk_in), .chip_sel_in(chip_sel_in),
    .chip_data_in(chip_data_in), .final_pixel_in(final_pixel_in), .pixel_valid_out(pixel_valid_out),
    .pixel_data_out(pixel_data_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .frame_done_out(frame_done_out), .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic void chk(string n, int a, int e);
    ncmp++;
    if (a != e) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endfunction

  always @(negedge clk_in) begin : mon
    exp_t e;
    if (!rst_in && (pixel_valid_out || error_out)) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        e = q.pop_front();
        chk("valid", int'(pixel_valid_out), int'(e.pix));
        if (e.pix) begin
          chk("data", int'(pixel_data_out), e.d);
          chk("hcount", int'(hcount_out), e.h);
          chk("vcount", int'(vcount_out), e.v);
          chk("frame_done", int'(frame_done_out), int'(e.fr));
        end
        chk("error", int'(error_out), int'(e.er));
      end
    end
  end

  task automatic nib(input logic [LN-1:0] n, input bit rise_cs);
    chip_data_in = n;
    #40 chip_clk_in = 1;
    if (rise_cs) chip_sel_in = 1;
    #40 chip_clk_in = 0;
  endtask

  task automatic pix(input logic [DW-1:0] d, input bit last, input bit rise_cs);
    exp_t e;
    e.pix = 1; e.d = int'(d); e.h = p % H; e.v = p / H; e.fr = last;
    e.er = last ? (p != HV - 1) : (p == HV - 1);
    q.push_back(e);
    p = last ? 0 : (p + 1) % HV;
    final_pixel_in = last;
    for (int i = 0; i < NIB; i++) nib(d[DW-1-i*LN -: LN], rise_cs && i == NIB - 1);
    final_pixel_in = 0;
  endtask

  task automatic cs_lo();
    chip_sel_in = 0;
    #40;
  endtask

  task automatic cs_hi();
    chip_sel_in = 1;
    #80;
  endtask

  task automatic trunc(input int k);
    exp_t e;
    e.pix = 0; e.d = 0; e.h = 0; e.v = 0; e.fr = 0; e.er = 1;
    cs_lo();
    for (int i = 0; i < k; i++) nib(4'($urandom), 0);
    q.push_back(e);
    cs_hi();
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk_in);
    repeat (10) @(posedge clk_in);
    chk("drain_pending", q.size(), 0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_valid"}, int'(pixel_valid_out), 0);
    chk({tag, "_data"}, int'(pixel_data_out), 0);
    chk({tag, "_h"}, int'(hcount_out), 0);
    chk({tag, "_v"}, int'(vcount_out), 0);
    chk({tag, "_frame"}, int'(frame_done_out), 0);
    chk({tag, "_err"}, int'(error_out), 0);
  endtask

  initial begin
    repeat (5) @(posedge clk_in);
    #1 chk_zero("reset");
    rst_in = 0;
    repeat (5) @(posedge clk_in);
    cs_lo(); pix(8'hA5, 0, 0); cs_hi(); drain();
    trunc(1); drain();
    cs_lo(); pix(8'h12, 0, 0); pix(8'h34, 0, 0); pix(8'h56, 0, 0); cs_hi(); drain();
    cs_lo();
    while (p != 50) pix(8'($urandom), 0, 0);
    pix(8'($urandom), 1, 0);
    for (int i = 0; i < HV; i++) begin
      pix(8'(i), i == HV - 1, 0);
      if (i % 8 == 7) begin cs_hi(); cs_lo(); end
    end
    pix(8'($urandom), 0, 1);
    cs_hi(); drain();
    for (int r = 0; r < 3; r++) begin
      do begin
        cs_lo();
        for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
          bit l;
          l = (p == HV - 1) || ($urandom % 64 == 0);
          pix(8'($urandom), l, 0);
          if (l) break;
        end
        cs_hi();
        if ($urandom % 6 == 0) trunc(1);
      end while (p != 0);
      drain();
    end
    cs_lo(); nib(4'($urandom), 0);
    rst_in = 1;
    repeat (3) @(posedge clk_in);
    #1 chk_zero("midreset");
    chip_sel_in = 1;
    repeat (10) @(posedge clk_in);
    rst_in = 0;
    p = 0;
    repeat (10) @(posedge clk_in);
    cs_lo(); pix(8'hFF, 0, 0); cs_hi(); drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time bound with %0d expected strobes pending", q.size());
    $fatal(1);
  end
endmodule
